// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS sweep path
package dds_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DWELL = 1'b1
   } sweep_state_e;

   localparam int SWEEP_STEP_MIN = 1;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - linear phase-increment sweep generator feeding the DDS
// Single FSM with dwell counter and a clamping step adder; every output is registered.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int PHASE_WIDTH = 16,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   cont_i,
   input  logic [PHASE_WIDTH-1:0] start_inc_i,
   input  logic [PHASE_WIDTH-1:0] end_inc_i,
   input  logic [PHASE_WIDTH-1:0] step_i,
   input  logic [DWELL_WIDTH-1:0] dwell_i,
   output logic [PHASE_WIDTH-1:0] phase_inc_o,
   output logic                   step_stb_o,
   output logic                   busy_o,
   output logic                   done_o
);

   sweep_state_e           state_q, state_d;
   logic [PHASE_WIDTH-1:0] start_q, end_q, step_q;
   logic [DWELL_WIDTH-1:0] dwell_q, cnt_q, cnt_d;
   logic                   cont_q, up_q;
   logic [PHASE_WIDTH-1:0] phase_d, next_val;
   logic                   stb_d, done_d, load_cfg;
   logic [PHASE_WIDTH:0]   sum, diff;

   // One extra bit exposes both overflow above 2^W-1 and borrow below 0.
   always_comb begin
      sum  = {1'b0, phase_inc_o} + {1'b0, step_q};
      diff = {1'b0, phase_inc_o} - {1'b0, step_q};
      if (up_q) begin
         next_val = (sum > {1'b0, end_q}) ? end_q : sum[PHASE_WIDTH-1:0];
      end else begin
         next_val = (diff[PHASE_WIDTH] || (diff[PHASE_WIDTH-1:0] < end_q))
                    ? end_q : diff[PHASE_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_inc_o;
      cnt_d    = cnt_q;
      stb_d    = 1'b0;
      done_d   = 1'b0;
      load_cfg = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               load_cfg = 1'b1;
               phase_d  = start_inc_i;
               cnt_d    = dwell_i;
               stb_d    = 1'b1;
               state_d  = DWELL;
            end
         end
         DWELL: begin
            if (stop_i) begin
               state_d = IDLE;
               phase_d = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DWELL_WIDTH'(1);
            end else if (phase_inc_o == end_q) begin
               if (cont_q) begin
                  phase_d = start_q;
                  stb_d   = 1'b1;
                  cnt_d   = dwell_q;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               phase_d = next_val;
               stb_d   = 1'b1;
               cnt_d   = dwell_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         phase_inc_o <= '0;
         step_stb_o  <= 1'b0;
         done_o      <= 1'b0;
         cnt_q       <= '0;
         start_q     <= '0;
         end_q       <= '0;
         step_q      <= '0;
         dwell_q     <= '0;
         cont_q      <= 1'b0;
         up_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_inc_o <= phase_d;
         step_stb_o  <= stb_d;
         done_o      <= done_d;
         cnt_q       <= cnt_d;
         if (load_cfg) begin
            start_q <= start_inc_i;
            end_q   <= end_inc_i;
            step_q  <= (step_i == '0) ? PHASE_WIDTH'(SWEEP_STEP_MIN) : step_i;
            dwell_q <= dwell_i;
            cont_q  <= cont_i;
            up_q    <= (end_inc_i >= start_inc_i);
         end
      end
   end

   assign busy_o = (state_q == DWELL);

endmodule
